// File: rtl/unary_scaled_add_if.sv
// rtl/unary_scaled_add_if.sv - control, bitstream inputs and selection outputs of the unary scaled adder
interface unary_scaled_add_if #(
  parameter int NUM_IN = 8
) ();
  localparam int SEL_W = $clog2(NUM_IN);

  logic              en;
  logic              clr;
  logic              mode;
  logic [NUM_IN-1:0] in;
  logic              out;
  logic              out_valid;
  logic [SEL_W-1:0]  sel_o;
  logic              wrap;

  modport master (
    output en, clr, mode, in,
    input  out, out_valid, sel_o, wrap
  );

  modport slave (
    input  en, clr, mode, in,
    output out, out_valid, sel_o, wrap
  );
endinterface

// File: rtl/unary_scaled_add.sv
// rtl/unary_scaled_add.sv - N-input unary scaled adder, round-robin or bit-reversed selection
module unary_scaled_add #(
  parameter int NUM_IN    = 8,
  parameter int START_DLY = 1,
  parameter int DEF_MODE  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  unary_scaled_add_if.slave    bus
);
  localparam int SEL_W = $clog2(NUM_IN);
  localparam int DLY_W = (START_DLY > 0) ? $clog2(START_DLY + 1) : 1;
  localparam logic [DLY_W-1:0] DLY_MAX = DLY_W'(START_DLY);
  localparam logic [SEL_W-1:0] LAST    = SEL_W'(NUM_IN - 1);
  localparam logic [SEL_W:0]   NUM_EXT = (SEL_W + 1)'(NUM_IN);

  function automatic logic [SEL_W-1:0] rev(input logic [SEL_W-1:0] v);
    logic [SEL_W-1:0] r;
    for (int i = 0; i < SEL_W; i++) r[i] = v[SEL_W-1-i];
    return r;
  endfunction

  logic [SEL_W-1:0] c;
  logic [DLY_W-1:0] dly;
  logic             mode_q;
  logic             out_q;
  logic             out_valid_q;
  logic [SEL_W-1:0] sel_q;
  logic             wrap_q;

  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] c_next;
  logic             wrap_next;
  logic [SEL_W:0]   n1;
  logic [SEL_W:0]   n2;

  // Bit-reversed mode walks c upward and skips counts whose reversal is out
  // of range; only odd counts can be invalid, so one skip always suffices.
  always_comb begin
    sel       = mode_q ? rev(c) : c;
    n1        = {1'b0, c} + (SEL_W + 1)'(1);
    n2        = {1'b0, c} + (SEL_W + 1)'(2);
    c_next    = n1[SEL_W-1:0];
    wrap_next = 1'b0;
    if (!mode_q) begin
      if (c == LAST) begin
        c_next    = '0;
        wrap_next = 1'b1;
      end
    end else if (n1[SEL_W]) begin
      c_next    = '0;
      wrap_next = 1'b1;
    end else if ({1'b0, rev(n1[SEL_W-1:0])} >= NUM_EXT) begin
      if (n2[SEL_W]) begin
        c_next    = '0;
        wrap_next = 1'b1;
      end else begin
        c_next = n2[SEL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c           <= '0;
      dly         <= '0;
      mode_q      <= 1'(DEF_MODE);
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      sel_q       <= '0;
      wrap_q      <= 1'b0;
    end else if (bus.clr) begin
      c           <= '0;
      dly         <= '0;
      mode_q      <= bus.mode;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      sel_q       <= '0;
      wrap_q      <= 1'b0;
    end else if (bus.en) begin
      if (dly != DLY_MAX) begin
        dly         <= dly + DLY_W'(1);
        out_valid_q <= 1'b0;
        wrap_q      <= 1'b0;
      end else begin
        out_q       <= bus.in[sel];
        sel_q       <= sel;
        out_valid_q <= 1'b1;
        wrap_q      <= wrap_next;
        c           <= c_next;
      end
    end else begin
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_o     = sel_q;
  assign bus.wrap      = wrap_q;
endmodule

// File: doc/unary_scaled_add.md
# unary_scaled_add

Parametrised N-input unary scaled adder. Each enabled cycle it forwards one input bitstream to the output, so a full period of N selections computes the scaled sum (Σ inᵢ)/N. The selection index is either round-robin or a bit-reversed (1-D low-discrepancy) sequence. The block supports any input count N ≥ 2, not only powers of two, and has an enable, a synchronous restart, a programmable start-up hold and a period-wrap flag. It sits in the scaled-add stage of unary datapaths, downstream of bitstream generators.

## Interface
- NUM_IN, 8: number of input bitstreams, ≥ 2.
- START_DLY, 1: enabled cycles after reset/clr during which the sequence holds and no output is valid, ≥ 0.
- DEF_MODE, 1: mode after reset (0 = round-robin, 1 = bit-reversed).
- SEL_W, derived: clog2(NUM_IN).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  advance one selection this cycle.
- clr  in  1  synchronous restart; latches mode.
- mode  in  1  selection mode, sampled only on clr.
- in  in  NUM_IN  input bitstream bits.
- out  out  1  selected input bit, registered.
- out_valid  out  1  out carries a selection from this period.
- sel_o  out  SEL_W  index that produced out.
- wrap  out  1  out is the last selection of a period.

## Operation
- **State:**
  - c: SEL_W-bit sequence counter.
  - dly: warm-up counter, 0..START_DLY.
  - mode_q: latched mode.
- **Reset:** c=0, dly=0, mode_q=DEF_MODE.
- **clr** (priority over en): c=0, dly=0, mode_q=mode. All outputs are 0 the following cycle.
- **Warm-up:** while dly<START_DLY, each en cycle does dly++. c holds at 0. out_valid=0 next cycle.
- **Run** (dly==START_DLY, en=1):
  - Current index: sel = c in mode 0, or rev(c) (SEL_W-bit reversal) in mode 1.
  - Register out=in[sel], sel_o=sel, out_valid=1.
- **Next c, mode 0:** c==NUM_IN-1 → 0 (wrap), else c+1.
- **Next c, mode 1:**
  - n=c+1. If rev(n)≥NUM_IN, then n=c+2.
  - Overflow past 2^SEL_W-1 → 0 (wrap).
  - Invalid reversed values occur only for odd n, so a single skip is always sufficient.
- **wrap** is registered alongside out. It is 1 when the next c is 0 through wrap.
- **en=0:**
  - c, dly and out hold.
  - out_valid, wrap = 0.
- **Period:** exactly NUM_IN valid selections per period, each index exactly once.
  - Constant inputs over one period give popcount(out) = popcount(in).
- The mode pin has no effect except at clr. mode_q is constant within a run, so c is always valid for the active mode.

## Timing
- All outputs are registered. Reset value of out, out_valid, sel_o and wrap is 0.
- Latency is 1 cycle: in/sel at cycle t → out at t+1.
- The first valid output appears at the (START_DLY+1)-th enabled cycle after reset/clr, visible the next cycle.
- Async reset mid-run returns the block to warm-up immediately.
- clr and en together: clr wins, no output is produced.
- Throughput is one selection per enabled cycle. There are no bubbles, including on skips (c+2 happens in a single cycle).

## Test plan
- **NUM_IN=8, mode 1, START_DLY=1, en held:** sel_o sequence 0,4,2,6,1,5,3,7 with wrap on 7, repeating. First out_valid appears on the 3rd cycle after reset release.
- **NUM_IN=6, mode 1:** sel_o 0,4,2,1,5,3 with wrap on 3. Period is 6 cycles; indices 6 and 7 never appear.
- **NUM_IN=6, clr with mode=0:** sel_o 0,1,2,3,4,5 with wrap on 5. in=6'b101101 gives out ones count 4 per period.
- **en toggling 1,0,1,0:** c advances only on en cycles. out_valid=0 and wrap=0 on en=0 cycles. The sequence matches the en-held case compressed.
- **Mode pin toggled mid-run without clr:** sequence is unchanged. Then clr with en=1 gives outputs 0 next cycle and warm-up restarts.
- **Async reset asserted mid-period, e.g. after sel_o=2:** all outputs drop to 0 immediately. After release the sequence restarts at 0 with mode=DEF_MODE.
